// File: rtl/maxnet_controller.sv
// Sequencing FSM for the four-PU competitive datapath: loads b, seeds a, then loops
// multiply -> accumulate -> check until end_signal or the iteration limit ends the run.
module maxnet_controller #(
    parameter int unsigned MAX_ITER = 31,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             z0,
    input  logic             z1,
    input  logic             z2,
    input  logic             z3,
    input  logic             end_signal,
    output logic             b_regs_en,
    output logic             a_regs_en,
    output logic             a_muxs,
    output logic             pu_mult_regs_en,
    output logic             pu_add_regs_en,
    output logic [1:0]       res_mux,
    output logic             done,
    output logic             busy,
    output logic             timeout,
    output logic             no_winner,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadB,
        StLoadA,
        StMult,
        StAdd,
        StCheck,
        StUpdate,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] MaxIterCnt = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e     state_q;
    state_e     state_d;
    logic       limit_hit;
    logic       all_zero_flags;
    logic [1:0] winner_idx;

    assign limit_hit      = (iter_count == MaxIterCnt);
    assign all_zero_flags = z0 & z1 & z2 & z3;

    // Lowest-index PU whose output is still non-zero; 0 when none survive.
    always_comb begin
        winner_idx = 2'd0;
        if (!z0) begin
            winner_idx = 2'd0;
        end else if (!z1) begin
            winner_idx = 2'd1;
        end else if (!z2) begin
            winner_idx = 2'd2;
        end else if (!z3) begin
            winner_idx = 2'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StLoadB;
            StLoadB:  state_d = StLoadA;
            StLoadA:  state_d = StMult;
            StMult:   state_d = StAdd;
            StAdd:    state_d = StCheck;
            StCheck:  state_d = (end_signal || limit_hit) ? StDone : StUpdate;
            StUpdate: state_d = StMult;
            StDone:   if (start) state_d = StLoadB;
            default:  state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state so each one is high exactly while
    // the FSM sits in the corresponding state, with no combinational path to the pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            b_regs_en       <= 1'b0;
            a_regs_en       <= 1'b0;
            a_muxs          <= 1'b0;
            pu_mult_regs_en <= 1'b0;
            pu_add_regs_en  <= 1'b0;
            done            <= 1'b0;
            busy            <= 1'b0;
            res_mux         <= 2'd0;
            timeout         <= 1'b0;
            no_winner       <= 1'b0;
            iter_count      <= '0;
        end else begin
            state_q         <= state_d;
            b_regs_en       <= (state_d == StLoadB);
            a_regs_en       <= (state_d == StLoadA) || (state_d == StUpdate);
            a_muxs          <= (state_d == StLoadA);
            pu_mult_regs_en <= (state_d == StMult);
            pu_add_regs_en  <= (state_d == StAdd);
            done            <= (state_d == StDone);
            busy            <= (state_d != StIdle) && (state_d != StDone);

            if (state_d == StLoadB) begin
                res_mux    <= 2'd0;
                timeout    <= 1'b0;
                no_winner  <= 1'b0;
                iter_count <= '0;
            end

            if (state_q == StCheck && state_d == StDone) begin
                res_mux   <= winner_idx;
                no_winner <= all_zero_flags;
                // end_signal has priority over the limit when both hold.
                timeout   <= ~end_signal;
            end

            if (state_q == StUpdate && !limit_hit) begin
                iter_count <= iter_count + CntOne;
            end
        end
    end

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Sequencing FSM for the four-PU competitive datapath: loads the b (input) registers, seeds the a (activation) registers, then iterates multiply → accumulate → check until the end-of-competition signal rises or an iteration limit is hit. It drives every enable and select of the datapath, latches the winning index into `res_mux`, and presents `done`. It sits beside the datapath in the top level and connects to it one-to-one.

## Interface
- `MAX_ITER`, 31: highest iteration count allowed before forced termination.
- `CNT_W`, 5: width of the iteration counter; must satisfy 2^CNT_W > MAX_ITER.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request; sampled in IDLE and DONE.
- `z0`,`z1`,`z2`,`z3`  in  1  PU zero flags; 1 means the PU output is zero.
- `end_signal`  in  1  end-of-competition flag from the datapath.
- `b_regs_en`  out  1  load enable for the b registers.
- `a_regs_en`  out  1  load enable for the a registers.
- `a_muxs`  out  1  a-register source select: 1 = b registers, 0 = PU outputs.
- `pu_mult_regs_en`  out  1  PU multiplier-stage register enable.
- `pu_add_regs_en`  out  1  PU adder-stage register enable.
- `res_mux`  out  2  index of the winning b register.
- `done`  out  1  result valid; datapath `result` is driven only while this is high.
- `busy`  out  1  high in every state except IDLE and DONE.
- `timeout`  out  1  run ended by the iteration limit, not by `end_signal`.
- `no_winner`  out  1  run ended with all four z flags at 1.
- `iter_count`  out  CNT_W  count of completed update passes.

## Operation
- FSM states: IDLE, LOAD_B, LOAD_A, MULT, ADD, CHECK, UPDATE, DONE. All outputs are Moore-decoded from the state register or come from registers. There are no Mealy paths.
- IDLE: all strobes 0. `start`=1 → LOAD_B.
- LOAD_B: `b_regs_en`=1. Clear `iter_count`, `timeout`, `no_winner`, `res_mux`. Next state is LOAD_A.
- LOAD_A: `a_muxs`=1, `a_regs_en`=1. Next state is MULT.
- MULT: `pu_mult_regs_en`=1. Next state is ADD.
- ADD: `pu_add_regs_en`=1. Next state is CHECK.
- CHECK: no strobes. The z flags and `end_signal` are sampled here.
  - If `end_signal`=1, go to DONE.
  - Else if `iter_count`==MAX_ITER, set `timeout` and go to DONE.
  - Else go to UPDATE.
  - On any exit to DONE, latch `res_mux` as the lowest index i with zi=0. If all zi=1, set `res_mux`=0 and `no_winner`=1.
- UPDATE: `a_muxs`=0, `a_regs_en`=1, `iter_count`+1. Next state is MULT.
- DONE: `done`=1. `res_mux`, `timeout`, `no_winner` and `iter_count` are held.
  - `start`=1 → LOAD_B (restart with new b inputs).
  - Otherwise stay in DONE.
- `start` is ignored in every busy state.
- `iter_count` never wraps. The limit check in CHECK guarantees it stops at MAX_ITER.
- If `end_signal` and the limit coincide in CHECK, `end_signal` wins and `timeout` stays 0.

## Timing
- Reset (async, `rst`=0): state IDLE. All outputs 0, including `res_mux`=0 and `iter_count`=0.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. The datapath register contents are don't-care afterwards.
- Release: first `start` sample at the first rising edge with `rst`=1.
- Let edge k sample `start`=1 in IDLE. The state sequence is:
  - LOAD_B during k..k+1
  - LOAD_A during k+1..k+2
  - MULT during k+2..k+3
  - ADD during k+3..k+4
  - CHECK during k+4..k+5
- If the run ends at the first CHECK, `done` rises after edge k+5.
- Each UPDATE pass adds 4 cycles (UPDATE, MULT, ADD, CHECK). A run with N updates raises `done` after edge k+5+4N.
- Worst case is N=MAX_ITER, giving 5+4·MAX_ITER cycles to `done`.
- `done` falls on the edge that leaves DONE. `busy` is high from the cycle after the IDLE→LOAD_B edge until DONE is entered.
- Only one strobe group is active per cycle. `a_regs_en` is never high in the same cycle as `b_regs_en` or either PU enable.

## Test plan
- Reset and idle: hold `rst`=0 with random inputs → all outputs 0. Release with `start`=0 for 10 cycles → still IDLE, all outputs 0.
- Immediate end: `start` pulse; z={1,0,1,1} and `end_signal`=1 at the first CHECK → exactly one LOAD_B, one LOAD_A, one MULT, one ADD strobe; `done` after 5 edges; `res_mux`=1, `iter_count`=0, `timeout`=0.
- Multi-iteration: `end_signal` rises at the third CHECK with z={1,1,1,0} → 2 UPDATE strobes with `a_muxs`=0; `done` after 13 edges; `res_mux`=3, `iter_count`=2.
- Timeout: MAX_ITER=3, `end_signal` held 0 → `done` after 17 edges; `timeout`=1, `iter_count`=3.
- Same run but `end_signal`=1 at the last CHECK → `timeout`=0.
- No winner and restart: all z=1 with `end_signal`=1 → `no_winner`=1, `res_mux`=0.
- Then assert `start` in DONE → `done` drops, LOAD_B follows, and all status outputs clear.
- Mid-run reset and start-ignore: toggle `start` during MULT/ADD → no effect. Pull `rst` low during ADD → all outputs 0 asynchronously (before the next edge), FSM returns to IDLE.
